// File: rtl/bk_mem_arbiter_if.sv
// Bundle linking the BK0011M video/copy/CPU requesters and the SDRAM command port to bk_mem_arbiter.
// slave is the arbiter's view (serves requesters, drives memory); master is the surrounding system.
interface bk_mem_arbiter_if;
  logic        vid_req;
  logic [24:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_dout;

  logic        cpy_req;
  logic [24:0] cpy_addr;
  logic        cpy_we;
  logic [15:0] cpy_din;
  logic        cpy_ack;
  logic [15:0] cpy_dout;

  logic        cpu_req;
  logic [24:0] cpu_addr;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_din;
  logic        cpu_ack;
  logic [15:0] cpu_dout;

  logic        mem_req;
  logic [24:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic [15:0] mem_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  cpy_req, cpy_addr, cpy_we, cpy_din,
    input  cpu_req, cpu_addr, cpu_we, cpu_be, cpu_din,
    input  mem_ack, mem_dout,
    output vid_ack, vid_dout, cpy_ack, cpy_dout, cpu_ack, cpu_dout,
    output mem_req, mem_addr, mem_we, mem_be, mem_din
  );

  modport master (
    output vid_req, vid_addr,
    output cpy_req, cpy_addr, cpy_we, cpy_din,
    output cpu_req, cpu_addr, cpu_we, cpu_be, cpu_din,
    output mem_ack, mem_dout,
    input  vid_ack, vid_dout, cpy_ack, cpy_dout, cpu_ack, cpu_dout,
    input  mem_req, mem_addr, mem_we, mem_be, mem_din
  );
endinterface

// File: rtl/bk_mem_arbiter.sv
// Video/copy/CPU arbiter and sequencer for the single shared BK0011M memory port.
// Optional CPU anti-starvation against copy DMA is enabled by defining BKARB_FAIRNESS_EN.
module bk_mem_arbiter #(
  parameter int TIMEOUT    = 63,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  bk_mem_arbiter_if.slave bus,
  output logic [1:0]      owner,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_VID  = 2'd1;
  localparam logic [1:0] OWN_CPY  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_owner;
  logic [1:0]        w_grant;
  logic [24:0]       r_cmd_addr;
  logic              r_cmd_we;
  logic [1:0]        r_cmd_be;
  logic [15:0]       r_cmd_din;
  logic [5:0]        r_tmo_cnt;
  logic              r_tmo_err;
  logic              w_done;
  logic              w_abort;
  logic              w_finish;
  logic              w_hold;
  logic              w_cpu_first;
  logic [2:0]        w_ack;
  logic [2:0][15:0]  w_dout;

  // The ack cycle doubles as the cooldown: nobody is granted while an ack is out,
  // so a requester re-requesting right away competes on equal terms a cycle later.
  assign w_hold = |w_ack;

`ifdef BKARB_FAIRNESS_EN
  logic [7:0] r_starve;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (w_grant == OWN_CPU) begin
      r_starve <= '0;
    end else if (w_grant == OWN_CPY && bus.cpu_req && !w_cpu_first) begin
      r_starve <= r_starve + 8'd1;
    end
  end

  assign w_cpu_first = (r_starve == 8'(STARVE_MAX));
`else
  // Strict priority: the comparison is false for every legal STARVE_MAX.
  assign w_cpu_first = (STARVE_MAX < 0);
`endif

  always_comb begin : arbitrate
    w_grant = OWN_NONE;
    if (r_state == S_IDLE && !w_hold) begin
      if (bus.vid_req) begin
        w_grant = OWN_VID;
      end else if (bus.cpu_req && w_cpu_first) begin
        w_grant = OWN_CPU;
      end else if (bus.cpy_req) begin
        w_grant = OWN_CPY;
      end else if (bus.cpu_req) begin
        w_grant = OWN_CPU;
      end
    end
  end

  always_comb begin : fsm_next
    w_state_next = r_state;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant != OWN_NONE) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.mem_ack) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_tmo_cnt == 6'(TIMEOUT)) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_finish = w_done | w_abort;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= OWN_NONE;
      r_cmd_addr <= '0;
      r_cmd_we   <= 1'b0;
      r_cmd_be   <= 2'b00;
      r_cmd_din  <= '0;
    end else if (w_grant != OWN_NONE) begin
      r_owner <= w_grant;
      case (w_grant)
        OWN_VID: begin
          r_cmd_addr <= bus.vid_addr;
          r_cmd_we   <= 1'b0;
          r_cmd_be   <= 2'b11;
          r_cmd_din  <= '0;
        end
        OWN_CPY: begin
          r_cmd_addr <= bus.cpy_addr;
          r_cmd_we   <= bus.cpy_we;
          r_cmd_be   <= 2'b11;
          r_cmd_din  <= bus.cpy_din;
        end
        default: begin
          r_cmd_addr <= bus.cpu_addr;
          r_cmd_we   <= bus.cpu_we;
          r_cmd_be   <= bus.cpu_be;
          r_cmd_din  <= bus.cpu_din;
        end
      endcase
    end else if (w_finish) begin
      r_owner <= OWN_NONE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_abort;
      if (r_state == S_IDLE || w_finish) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 6'd1;
      end
    end
  end

  // Per-requester ack pulse and data register; index gi serves owner code gi+1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_resp
    logic        r_ack;
    logic [15:0] r_dout;
    logic        w_mine;

    assign w_mine = (r_owner == 2'(gi + 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_ack  <= 1'b0;
        r_dout <= '0;
      end else begin
        r_ack <= w_finish && w_mine;
        if (w_abort && w_mine) begin
          r_dout <= 16'hFFFF;
        end else if (w_done && w_mine && !r_cmd_we) begin
          r_dout <= bus.mem_dout;
        end
      end
    end

    assign w_ack[gi]  = r_ack;
    assign w_dout[gi] = r_dout;
  end

  assign bus.vid_ack  = w_ack[0];
  assign bus.vid_dout = w_dout[0];
  assign bus.cpy_ack  = w_ack[1];
  assign bus.cpy_dout = w_dout[1];
  assign bus.cpu_ack  = w_ack[2];
  assign bus.cpu_dout = w_dout[2];

  assign bus.mem_req  = (r_state != S_IDLE);
  assign bus.mem_addr = r_cmd_addr;
  assign bus.mem_we   = r_cmd_we;
  assign bus.mem_be   = r_cmd_be;
  assign bus.mem_din  = r_cmd_din;

  assign owner       = r_owner;
  assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_bk_mem_arbiter.sv
// Scoreboard bench for bk_mem_arbiter: per-requester expected-data queues, a memory
// responder with programmable latency, and a log of issued commands.
module tb_bk_mem_arbiter;
  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] owner;
  logic       timeout_err;

  bk_mem_arbiter_if bus ();

  bk_mem_arbiter #(.TIMEOUT(63), .STARVE_MAX(4)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .bus         (bus),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  own;
    logic [24:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] din;
  } cmd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_delay = 0;
  bit stray_ack = 1'b0;
  bit cpy_auto = 1'b0;
  int age = 0;
  int t_rise = 0;
  int last_lat = 0;
  int ack_total = 0;
  int ack_cyc = 0;
  int tmo_count = 0;
  int tmo_cyc = 0;
  logic [15:0] exp_vid[$];
  logic [15:0] exp_cpy[$];
  logic [15:0] exp_cpu[$];
  logic [15:0] dout_model [3];
  cmd_t cmd_q[$];

  function automatic logic [15:0] mem_data(input logic [24:0] a);
    if (a == 25'h00100) return 16'hA5C3;
    return a[15:0] ^ 16'h3C3C;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #2;
    end
  endtask

  task automatic wait_acks(input int target, input int budget, output bit ok);
    int n = 0;
    while (ack_total < target && n < budget) begin
      tick();
      n++;
    end
    ok = (ack_total >= target);
  endtask

  // Memory responder, ack scoreboard and requester behaviour, evaluated once per cycle.
  initial begin : env
    logic [15:0] e;
    forever begin
      @(posedge clk_sys);
      #1;
      cyc++;
      if (timeout_err) begin
        tmo_count++;
        tmo_cyc = cyc;
      end
      if (bus.vid_ack || bus.cpy_ack || bus.cpu_ack) begin
        ack_total++;
        ack_cyc  = cyc;
        last_lat = cyc - t_rise;
        checks++;
        if (bus.mem_req) begin
          errors++;
          $display("FAIL mem_req_gap: mem_req=%0d during ack cycle, required 0", bus.mem_req);
        end
      end
      if (bus.vid_ack) begin
        checks++;
        if (exp_vid.size() == 0) begin
          errors++;
          $display("FAIL vid_ack_extra: got ack with dout %h, required no ack", bus.vid_dout);
        end else begin
          e = exp_vid.pop_front();
          if (bus.vid_dout !== e) begin
            errors++;
            $display("FAIL vid_dout: got %h required %h", bus.vid_dout, e);
          end
        end
        bus.vid_req = 1'b0;
      end
      if (bus.cpy_ack) begin
        checks++;
        if (exp_cpy.size() == 0) begin
          errors++;
          $display("FAIL cpy_ack_extra: got ack with dout %h, required no ack", bus.cpy_dout);
        end else begin
          e = exp_cpy.pop_front();
          if (bus.cpy_dout !== e) begin
            errors++;
            $display("FAIL cpy_dout: got %h required %h", bus.cpy_dout, e);
          end
        end
        if (cpy_auto) begin
          bus.cpy_addr = bus.cpy_addr + 25'd1;
          exp_cpy.push_back(mem_data(bus.cpy_addr));
        end else begin
          bus.cpy_req = 1'b0;
        end
      end
      if (bus.cpu_ack) begin
        checks++;
        if (exp_cpu.size() == 0) begin
          errors++;
          $display("FAIL cpu_ack_extra: got ack with dout %h, required no ack", bus.cpu_dout);
        end else begin
          e = exp_cpu.pop_front();
          if (bus.cpu_dout !== e) begin
            errors++;
            $display("FAIL cpu_dout: got %h required %h", bus.cpu_dout, e);
          end
        end
        bus.cpu_req = 1'b0;
      end
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (age == 0) begin
          t_rise = cyc;
          cmd_q.push_back(cmd_t'{owner, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_din});
          $display("cmd owner=%0d addr=%h we=%0d be=%b din=%h", owner, bus.mem_addr,
                   bus.mem_we, bus.mem_be, bus.mem_din);
        end
        if (mem_delay >= 0 && age == mem_delay) begin
          bus.mem_ack  = 1'b1;
          bus.mem_dout = mem_data(bus.mem_addr);
        end
        age++;
      end else begin
        age = 0;
        if (stray_ack) begin
          bus.mem_ack  = 1'b1;
          bus.mem_dout = 16'hDEAD;
          stray_ack    = 1'b0;
        end
      end
    end
  end

  task automatic test_reset;
    reset_n = 1'b0;
    tick(2);
    checks++;
    if ({bus.mem_req, owner, timeout_err, bus.vid_ack, bus.cpy_ack, bus.cpu_ack} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0", {bus.mem_req, owner, timeout_err,
               bus.vid_ack, bus.cpy_ack, bus.cpu_ack});
    end
    checks++;
    if ({bus.vid_dout, bus.cpy_dout, bus.cpu_dout} !== 48'd0) begin
      errors++;
      $display("FAIL reset_dout: got %h required 0", {bus.vid_dout, bus.cpy_dout, bus.cpu_dout});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_din} !== 44'd0) begin
      errors++;
      $display("FAIL reset_cmd: got %h required 0", {bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_din});
    end
    reset_n = 1'b1;
    tick(2);
    checks++;
    if ({bus.mem_req, owner} !== 3'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b required 0", {bus.mem_req, owner});
    end
    $display("txn reset done");
  endtask

  task automatic test_cpu_read;
    bus.cpu_addr = 25'h00100;
    bus.cpu_we   = 1'b0;
    bus.cpu_be   = 2'b11;
    bus.cpu_din  = 16'h0;
    bus.cpu_req  = 1'b1;
    dout_model[2] = mem_data(25'h00100);
    exp_cpu.push_back(dout_model[2]);
    tick();
    checks++;
    if (owner !== 2'd3 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL cpu_read_grant: got owner=%0d mem_req=%0d required 3/1", owner, bus.mem_req);
    end
    tick();
    checks++;
    if (bus.cpu_ack !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL cpu_read_ack: got ack=%0d owner=%0d required 1/0", bus.cpu_ack, owner);
    end
    checks++;
    if (bus.cpu_dout !== 16'hA5C3) begin
      errors++;
      $display("FAIL cpu_read_data: got %h required a5c3", bus.cpu_dout);
    end
    checks++;
    if (last_lat != 1) begin
      errors++;
      $display("FAIL cpu_read_latency: got %0d required 1", last_lat);
    end
    tick();
    checks++;
    if (bus.cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_ack_pulse: got %0d required 0", bus.cpu_ack);
    end
    checks++;
    if (cmd_q.size() != 1 || cmd_q[0].addr !== 25'h00100 || cmd_q[0].we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_cmd: got %0d entries required one read of 100", cmd_q.size());
    end
    cmd_q.delete();
    $display("txn cpu_read addr=00100 dout=%h", bus.cpu_dout);
  endtask

  task automatic test_cpu_write;
    bit ok;
    cmd_t c;
    int target = ack_total + 1;
    bus.cpu_addr = 25'h00200;
    bus.cpu_we   = 1'b1;
    bus.cpu_be   = 2'b01;
    bus.cpu_din  = 16'h1234;
    bus.cpu_req  = 1'b1;
    exp_cpu.push_back(dout_model[2]);
    wait_acks(target, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cpu_write_done: got %0d acks required %0d", ack_total, target);
    end
    tick();
    checks++;
    if (cmd_q.size() != 1) begin
      errors++;
      $display("FAIL cpu_write_cmdcount: got %0d required 1", cmd_q.size());
    end else begin
      c = cmd_q.pop_front();
      if ({c.own, c.we, c.be, c.din} !== {2'd3, 1'b1, 2'b01, 16'h1234}) begin
        errors++;
        $display("FAIL cpu_write_cmd: got own=%0d we=%0d be=%b din=%h required 3/1/01/1234",
                 c.own, c.we, c.be, c.din);
      end
    end
    checks++;
    if (bus.cpu_dout !== 16'hA5C3) begin
      errors++;
      $display("FAIL cpu_write_dout_kept: got %h required a5c3", bus.cpu_dout);
    end
    $display("txn cpu_write addr=00200 be=01 din=1234");
  endtask

  task automatic test_arbitration;
    bit ok;
    cmd_t c;
    int target = ack_total + 3;
    bus.vid_addr = 25'h00300;
    bus.vid_req  = 1'b1;
    bus.cpy_addr = 25'h00400;
    bus.cpy_we   = 1'b0;
    bus.cpy_din  = 16'h0;
    bus.cpy_req  = 1'b1;
    bus.cpu_addr = 25'h00500;
    bus.cpu_we   = 1'b0;
    bus.cpu_be   = 2'b10;
    bus.cpu_req  = 1'b1;
    dout_model[0] = mem_data(25'h00300);
    dout_model[1] = mem_data(25'h00400);
    dout_model[2] = mem_data(25'h00500);
    exp_vid.push_back(dout_model[0]);
    exp_cpy.push_back(dout_model[1]);
    exp_cpu.push_back(dout_model[2]);
    wait_acks(target, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL arb_done: got %0d acks required %0d", ack_total, target);
    end
    tick(3);
    checks++;
    if (ack_total != target) begin
      errors++;
      $display("FAIL arb_ack_count: got %0d required %0d", ack_total, target);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL arb_order_%0d: got no grant required owner %0d", i, i + 1);
      end else begin
        c = cmd_q.pop_front();
        if (c.own !== 2'(i + 1)) begin
          errors++;
          $display("FAIL arb_order_%0d: got owner %0d required %0d", i, c.own, i + 1);
        end
        if (i < 2 && c.be !== 2'b11) begin
          errors++;
          $display("FAIL arb_be_%0d: got %b required 11", i, c.be);
        end
        if (i == 0 && c.we !== 1'b0) begin
          errors++;
          $display("FAIL arb_vid_we: got %0d required 0", c.we);
        end
      end
    end
    $display("txn arbitration vid/cpy/cpu served");
  endtask

  task automatic test_copy_write_wait;
    bit ok;
    cmd_t c;
    int target = ack_total + 1;
    mem_delay    = 3;
    bus.cpy_addr = 25'h00600;
    bus.cpy_we   = 1'b1;
    bus.cpy_din  = 16'hBEEF;
    bus.cpy_req  = 1'b1;
    exp_cpy.push_back(dout_model[1]);
    wait_acks(target, 20, ok);
    checks++;
    if (!ok || last_lat != 4) begin
      errors++;
      $display("FAIL cpy_wait_latency: got %0d required 4", last_lat);
    end
    tick();
    checks++;
    if (cmd_q.size() != 1) begin
      errors++;
      $display("FAIL cpy_write_cmdcount: got %0d required 1", cmd_q.size());
    end else begin
      c = cmd_q.pop_front();
      if ({c.own, c.we, c.be, c.din} !== {2'd2, 1'b1, 2'b11, 16'hBEEF}) begin
        errors++;
        $display("FAIL cpy_write_cmd: got own=%0d we=%0d be=%b din=%h required 2/1/11/beef",
                 c.own, c.we, c.be, c.din);
      end
    end
    mem_delay = 0;
    $display("txn cpy_write addr=00600 din=beef latency=%0d", last_lat);
  endtask

  task automatic test_timeout;
    bit ok;
    int target;
    int tmo_base = tmo_count;
    mem_delay = -1;
    for (int k = 0; k < 2; k++) begin
      target = ack_total + 1;
      if (k == 0) begin
        bus.cpu_addr = 25'h00700;
        bus.cpu_we   = 1'b0;
        bus.cpu_be   = 2'b11;
        bus.cpu_req  = 1'b1;
        dout_model[2] = 16'hFFFF;
        exp_cpu.push_back(16'hFFFF);
      end else begin
        bus.cpy_addr = 25'h00777;
        bus.cpy_we   = 1'b1;
        bus.cpy_din  = 16'h5555;
        bus.cpy_req  = 1'b1;
        dout_model[1] = 16'hFFFF;
        exp_cpy.push_back(16'hFFFF);
      end
      wait_acks(target, 100, ok);
      checks++;
      if (!ok || last_lat != 64) begin
        errors++;
        $display("FAIL timeout_latency_%0d: got %0d required 64", k, last_lat);
      end
      checks++;
      if (tmo_count != tmo_base + k + 1 || tmo_cyc != ack_cyc) begin
        errors++;
        $display("FAIL timeout_err_%0d: got %0d pulses required %0d with ack", k, tmo_count - tmo_base, k + 1);
      end
      tick(2);
      $display("txn timeout %0d latency=%0d", k, last_lat);
    end
    checks++;
    if (bus.cpu_dout !== 16'hFFFF || bus.cpy_dout !== 16'hFFFF) begin
      errors++;
      $display("FAIL timeout_dout: got cpu %h cpy %h required ffff", bus.cpu_dout, bus.cpy_dout);
    end
    mem_delay = 0;
    target = ack_total + 1;
    bus.vid_addr = 25'h00800;
    bus.vid_req  = 1'b1;
    dout_model[0] = mem_data(25'h00800);
    exp_vid.push_back(dout_model[0]);
    wait_acks(target, 20, ok);
    checks++;
    if (!ok || last_lat != 1 || tmo_count != tmo_base + 2) begin
      errors++;
      $display("FAIL timeout_recover: got latency %0d pulses %0d required 1/2", last_lat, tmo_count - tmo_base);
    end
    tick(2);
    cmd_q.delete();
    $display("txn timeout_recover vid dout=%h", bus.vid_dout);
  endtask

  task automatic test_stray_ack;
    bit ok;
    int base = ack_total;
    stray_ack = 1'b1;
    tick(3);
    checks++;
    if (ack_total != base || owner !== 2'd0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got acks %0d owner %0d mem_req %0d required 0/0/0",
               ack_total - base, owner, bus.mem_req);
    end
    bus.cpu_addr = 25'h00900;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    dout_model[2] = mem_data(25'h00900);
    exp_cpu.push_back(dout_model[2]);
    wait_acks(base + 1, 20, ok);
    checks++;
    if (!ok || last_lat != 1) begin
      errors++;
      $display("FAIL stray_then_read: got latency %0d required 1", last_lat);
    end
    tick(2);
    cmd_q.delete();
    $display("txn stray_ack ignored");
  endtask

  task automatic test_starve;
    bit ok;
    int n = 0;
    int need;
`ifdef BKARB_FAIRNESS_EN
    need = 5;
`else
    need = 8;
`endif
    cmd_q.delete();
    bus.cpy_addr = 25'h01000;
    bus.cpy_we   = 1'b0;
    bus.cpy_req  = 1'b1;
    exp_cpy.push_back(mem_data(25'h01000));
    bus.cpu_addr = 25'h02000;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    exp_cpu.push_back(mem_data(25'h02000));
    cpy_auto = 1'b1;
    while (cmd_q.size() < need && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_q.size() < need) begin
      errors++;
      $display("FAIL starve_progress: got %0d grants required %0d", cmd_q.size(), need);
    end else begin
      for (int i = 0; i < need; i++) begin
        checks++;
        if (cmd_q[i].own !== ((i == 4 && need == 5) ? 2'd3 : 2'd2)) begin
          errors++;
          $display("FAIL starve_grant_%0d: got owner %0d required %0d", i, cmd_q[i].own,
                   (i == 4 && need == 5) ? 3 : 2);
        end
      end
    end
    cpy_auto = 1'b0;
    n = 0;
    while ((exp_cpy.size() != 0 || exp_cpu.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (exp_cpy.size() != 0 || exp_cpu.size() != 0) begin
      errors++;
      $display("FAIL starve_drain: got %0d/%0d pending required 0/0", exp_cpy.size(), exp_cpu.size());
    end
    tick(3);
    dout_model[1] = bus.cpy_dout;
    cmd_q.delete();
    $display("txn starve grants=%0d", need);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int base;
    mem_delay    = -1;
    bus.cpu_addr = 25'h00A00;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    tick(4);
    checks++;
    if (bus.mem_req !== 1'b1 || owner !== 2'd3) begin
      errors++;
      $display("FAIL reset_mid_wait: got mem_req %0d owner %0d required 1/3", bus.mem_req, owner);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, owner, timeout_err, bus.vid_ack, bus.cpy_ack, bus.cpu_ack} !== 7'd0 ||
        {bus.vid_dout, bus.cpy_dout, bus.cpu_dout, bus.mem_addr} !== 73'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got mem_req %0d owner %0d addr %h required all 0",
               bus.mem_req, owner, bus.mem_addr);
    end
    bus.cpu_req = 1'b0;
    dout_model[0] = 16'h0;
    dout_model[1] = 16'h0;
    dout_model[2] = 16'h0;
    tick(2);
    reset_n   = 1'b1;
    mem_delay = 0;
    tick();
    cmd_q.delete();
    base = ack_total;
    bus.vid_addr = 25'h00B00;
    bus.vid_req  = 1'b1;
    exp_vid.push_back(mem_data(25'h00B00));
    wait_acks(base + 1, 20, ok);
    checks++;
    if (!ok || last_lat != 1 || cmd_q.size() != 1 || cmd_q[0].own !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_recover: got latency %0d grants %0d required 1/1", last_lat, cmd_q.size());
    end
    tick(2);
    $display("txn reset_mid recovered vid dout=%h", bus.vid_dout);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset_n      = 1'b0;
    bus.vid_req  = 1'b0;
    bus.vid_addr = '0;
    bus.cpy_req  = 1'b0;
    bus.cpy_addr = '0;
    bus.cpy_we   = 1'b0;
    bus.cpy_din  = '0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_we   = 1'b0;
    bus.cpu_be   = 2'b11;
    bus.cpu_din  = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
    dout_model[0] = 16'h0;
    dout_model[1] = 16'h0;
    dout_model[2] = 16'h0;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_arbitration();
    test_copy_write_wait();
    test_timeout();
    test_stray_ack();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
